stack_sequencer: RTL and testbench

- Control stage directly upstream of the stack-pointer counter. Owns the counter's clk_en-qualified increment/decrement controls (en, dir) and reads back its address output.
- Turns single PUSH/POP requests (byte or 16-bit word) from the instruction sequencer into ordered stack-RAM accesses and SP steps.
- Tracks stack occupancy and reports overflow/underflow without corrupting memory or SP.

---
 rtl/stack_sequencer.sv | 136 +++++++++++++
 tb/tb_stack_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - push/pop sequencer driving the stack-pointer counter and stack RAM
// SP points to the next free byte: push writes then decrements, pop increments then reads.
module stack_sequencer #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic        req_word,
    input  logic [15:0] req_data,
    input  logic [7:0]  sp_addr,
    output logic        sp_en,
    output logic        sp_dir,
    output logic [7:0]  mem_addr,
    output logic        mem_we,
    output logic        mem_re,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        rsp_done,
    output logic        rsp_err,
    output logic [15:0] rsp_data,
    output logic [8:0]  depth_count,
    output logic        empty,
    output logic        full
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PUSH_HI = 3'd1;
    localparam logic [2:0] S_PUSH_LO = 3'd2;
    localparam logic [2:0] S_POP_INC = 3'd3;
    localparam logic [2:0] S_POP_RD  = 3'd4;
    localparam logic [2:0] S_POP_CAP = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic [9:0] DEPTH_W = 10'(DEPTH);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic        word_q;
    logic        second_q;
    logic        err_q;
    logic [15:0] data_q;
    logic [7:0]  lo_byte_q;

    logic        accept;
    logic [9:0]  need;
    logic        push_ovf;
    logic        pop_unf;
    logic        req_bad;
    logic        push_st;

    assign accept   = req_valid & req_ready & clk_en;
    assign need     = req_word ? 10'd2 : 10'd1;
    assign push_ovf = ({1'b0, depth_count} + need) > DEPTH_W;
    assign pop_unf  = {1'b0, depth_count} < need;
    // A word op is checked whole so it is never half-done.
    assign req_bad  = req_op ? pop_unf : push_ovf;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_bad)
                        state_nxt = S_DONE;
                    else if (req_op)
                        state_nxt = S_POP_INC;
                    else if (req_word)
                        state_nxt = S_PUSH_HI;
                    else
                        state_nxt = S_PUSH_LO;
                end
            end
            S_PUSH_HI: state_nxt = S_PUSH_LO;
            S_PUSH_LO: state_nxt = S_DONE;
            S_POP_INC: state_nxt = S_POP_RD;
            S_POP_RD:  state_nxt = S_POP_CAP;
            S_POP_CAP: state_nxt = (word_q && !second_q) ? S_POP_INC : S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            depth_count <= 9'd0;
            rsp_data    <= 16'h0000;
            word_q      <= 1'b0;
            second_q    <= 1'b0;
            err_q       <= 1'b0;
            data_q      <= 16'h0000;
            lo_byte_q   <= 8'h00;
        end else if (clk_en) begin
            state <= state_nxt;
            if (accept) begin
                word_q   <= req_word;
                data_q   <= req_data;
                err_q    <= req_bad;
                second_q <= 1'b0;
            end
            if (state == S_PUSH_HI || state == S_PUSH_LO)
                depth_count <= depth_count + 9'd1;
            else if (state == S_POP_INC)
                depth_count <= depth_count - 9'd1;
            // rsp_data only moves when a pop finishes, so it holds across pushes and errors.
            if (state == S_POP_CAP) begin
                if (word_q && !second_q) begin
                    lo_byte_q <= mem_rdata;
                    second_q  <= 1'b1;
                end else if (word_q) begin
                    rsp_data <= {mem_rdata, lo_byte_q};
                end else begin
                    rsp_data <= {8'h00, mem_rdata};
                end
            end
        end
    end

    assign push_st   = (state == S_PUSH_HI) || (state == S_PUSH_LO);
    assign req_ready = (state == S_IDLE);
    assign sp_en     = clk_en & (push_st | (state == S_POP_INC));
    assign sp_dir    = push_st;
    assign mem_addr  = sp_addr;
    assign mem_we    = clk_en & push_st;
    assign mem_re    = clk_en & (state == S_POP_RD);
    assign mem_wdata = (state == S_PUSH_HI) ? data_q[15:8] : data_q[7:0];
    assign rsp_done  = clk_en & (state == S_DONE);
    assign rsp_err   = rsp_done & err_q;
    assign empty     = (depth_count == 9'd0);
    assign full      = (depth_count == DEPTH_W[8:0]);

endmodule

// File: tb/tb_stack_sequencer.sv
// tb/tb_stack_sequencer.sv - bench for stack_sequencer with SP counter and RAM models
module tb_stack_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b1;
    bit   toggle_on = 1'b0;

    logic        req_valid [2];
    logic        req_op    [2];
    logic        req_word  [2];
    logic [15:0] req_data  [2];
    logic        sp_load   [2];
    logic        req_ready [2];
    logic        sp_en     [2];
    logic        sp_dir    [2];
    logic        mem_we    [2];
    logic        mem_re    [2];
    logic        rsp_done  [2];
    logic        rsp_err   [2];
    logic        empty     [2];
    logic        full      [2];
    logic [7:0]  mem_addr  [2];
    logic [7:0]  mem_wdata [2];
    logic [7:0]  mem_rdata [2];
    logic [7:0]  sp        [2];
    logic [15:0] rsp_data  [2];
    logic [8:0]  depth_count [2];

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    int n_sp    [2] = '{0, 0};
    int n_mem   [2] = '{0, 0};
    int n_done  [2] = '{0, 0};
    int n_stall [2] = '{0, 0};

    int passed = 0;
    int total  = 0;

    typedef struct {
        bit          err;
        logic [15:0] data;
        int          lat;
        int          steps;
    } exp_t;

    typedef struct {
        bit          op;
        bit          word;
        logic [15:0] din;
        bit          err;
        logic [15:0] dout;
        int          lat;
        int          steps;
        logic [8:0]  depth;
        logic [7:0]  spv;
    } vec_t;

    exp_t sb[$];
    vec_t tv[9];

    stack_sequencer #(.DEPTH(256)) u_big (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
        .req_word(req_word[0]), .req_data(req_data[0]), .sp_addr(sp[0]),
        .sp_en(sp_en[0]), .sp_dir(sp_dir[0]), .mem_addr(mem_addr[0]),
        .mem_we(mem_we[0]), .mem_re(mem_re[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .rsp_done(rsp_done[0]), .rsp_err(rsp_err[0]),
        .rsp_data(rsp_data[0]), .depth_count(depth_count[0]),
        .empty(empty[0]), .full(full[0])
    );

    stack_sequencer #(.DEPTH(4)) u_small (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
        .req_word(req_word[1]), .req_data(req_data[1]), .sp_addr(sp[1]),
        .sp_en(sp_en[1]), .sp_dir(sp_dir[1]), .mem_addr(mem_addr[1]),
        .mem_we(mem_we[1]), .mem_re(mem_re[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .rsp_done(rsp_done[1]), .rsp_err(rsp_err[1]),
        .rsp_data(rsp_data[1]), .depth_count(depth_count[1]),
        .empty(empty[1]), .full(full[1])
    );

    always #5 clk = ~clk;

    // clk_en changes just after the rising edge so it is stable at every sample point.
    initial forever begin
        @(posedge clk);
        #1;
        clk_en = toggle_on ? ~clk_en : 1'b1;
    end

    always @(posedge clk) begin
        if (sp_load[0]) sp[0] <= 8'hFF;
        else if (clk_en && sp_en[0]) sp[0] <= sp_dir[0] ? sp[0] - 8'd1 : sp[0] + 8'd1;
        if (sp_load[1]) sp[1] <= 8'hFF;
        else if (clk_en && sp_en[1]) sp[1] <= sp_dir[1] ? sp[1] - 8'd1 : sp[1] + 8'd1;
        if (mem_we[0]) mem0[mem_addr[0]] <= mem_wdata[0];
        if (mem_re[0]) mem_rdata[0] <= mem0[mem_addr[0]];
        if (mem_we[1]) mem1[mem_addr[1]] <= mem_wdata[1];
        if (mem_re[1]) mem_rdata[1] <= mem1[mem_addr[1]];
        n_sp[0]   <= n_sp[0]   + (sp_en[0] ? 1 : 0);
        n_sp[1]   <= n_sp[1]   + (sp_en[1] ? 1 : 0);
        n_mem[0]  <= n_mem[0]  + ((mem_we[0] | mem_re[0]) ? 1 : 0);
        n_mem[1]  <= n_mem[1]  + ((mem_we[1] | mem_re[1]) ? 1 : 0);
        n_done[0] <= n_done[0] + (rsp_done[0] ? 1 : 0);
        n_done[1] <= n_done[1] + (rsp_done[1] ? 1 : 0);
        n_stall[0] <= n_stall[0] + ((!clk_en && (sp_en[0] | mem_we[0] | mem_re[0] | rsp_done[0])) ? 1 : 0);
        n_stall[1] <= n_stall[1] + ((!clk_en && (sp_en[1] | mem_we[1] | mem_re[1] | rsp_done[1])) ? 1 : 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic exp_t mk(input bit err, input logic [15:0] d, input int lat, input int steps);
        exp_t e;
        e.err = err; e.data = d; e.lat = lat; e.steps = steps;
        return e;
    endfunction

    task automatic do_op(input string tag, input int u, input bit op, input bit word,
                         input logic [15:0] din, input exp_t e);
        int lat;
        int sp0;
        int mem0_cnt;
        bit got;
        bit err_seen;
        logic [15:0] data_seen;
        exp_t x;
        sb.push_back(e);
        @(negedge clk);
        req_valid[u] = 1'b1;
        req_op[u]    = op;
        req_word[u]  = word;
        req_data[u]  = din;
        while (!clk_en) @(negedge clk);
        sp0 = n_sp[u];
        mem0_cnt = n_mem[u];
        @(negedge clk);
        req_valid[u] = 1'b0;
        lat = 0;
        got = 1'b0;
        err_seen = 1'b0;
        data_seen = 16'h0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (clk_en) lat++;
            if (rsp_done[u]) begin
                got = 1'b1;
                err_seen = rsp_err[u];
                data_seen = rsp_data[u];
            end else begin
                @(negedge clk);
            end
        end
        x = sb.pop_front();
        chk({tag, " done_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, " err"}, 32'(err_seen), 32'(x.err));
            chk({tag, " data"}, 32'(data_seen), 32'(x.data));
            chk({tag, " latency"}, lat, x.lat);
            @(negedge clk);
            chk({tag, " sp_steps"}, n_sp[u] - sp0, x.steps);
            chk({tag, " mem_accesses"}, n_mem[u] - mem0_cnt, x.steps);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sp_load[0] = 1'b1;
        sp_load[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sp_load[0] = 1'b0;
        sp_load[1] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int m0;
        int s0;
        bit found;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0;
            req_op[u]    = 1'b0;
            req_word[u]  = 1'b0;
            req_data[u]  = 16'h0;
            sp_load[u]   = 1'b0;
        end

        tv[0] = '{0, 0, 16'h00A5, 0, 16'h0000, 2, 1, 9'd1, 8'hFE};
        tv[1] = '{0, 1, 16'h1234, 0, 16'h0000, 3, 2, 9'd3, 8'hFC};
        tv[2] = '{1, 1, 16'h0000, 0, 16'h1234, 7, 2, 9'd1, 8'hFE};
        tv[3] = '{1, 1, 16'h0000, 1, 16'h1234, 1, 0, 9'd1, 8'hFE};
        tv[4] = '{1, 0, 16'h0000, 0, 16'h00A5, 4, 1, 9'd0, 8'hFF};
        tv[5] = '{1, 0, 16'h0000, 1, 16'h00A5, 1, 0, 9'd0, 8'hFF};
        tv[6] = '{0, 1, 16'hBEEF, 0, 16'h00A5, 3, 2, 9'd2, 8'hFD};
        tv[7] = '{1, 0, 16'h0000, 0, 16'h00EF, 4, 1, 9'd1, 8'hFE};
        tv[8] = '{1, 0, 16'h0000, 0, 16'h00BE, 4, 1, 9'd0, 8'hFF};

        do_reset();
        chk("rst req_ready", 32'(req_ready[0]), 32'd1);
        chk("rst depth", 32'(depth_count[0]), 32'd0);
        chk("rst empty", 32'(empty[0]), 32'd1);
        chk("rst full", 32'(full[0]), 32'd0);
        chk("rst rsp_data", 32'(rsp_data[0]), 32'd0);
        chk("rst rsp_done", 32'(rsp_done[0]), 32'd0);
        chk("rst rsp_err", 32'(rsp_err[0]), 32'd0);
        chk("rst strobes", 32'({sp_en[0], mem_we[0], mem_re[0]}), 32'd0);
        chk("rst sp", 32'(sp[0]), 32'hFF);

        for (int i = 0; i < 9; i++) begin
            do_op($sformatf("vec%0d", i), 0, tv[i].op, tv[i].word, tv[i].din,
                  mk(tv[i].err, tv[i].dout, tv[i].lat, tv[i].steps));
            chk($sformatf("vec%0d depth", i), 32'(depth_count[0]), 32'(tv[i].depth));
            chk($sformatf("vec%0d sp", i), 32'(sp[0]), 32'(tv[i].spv));
            if (i == 1) begin
                chk("mem FF", 32'(mem0[8'hFF]), 32'hA5);
                chk("mem FE", 32'(mem0[8'hFE]), 32'h12);
                chk("mem FD", 32'(mem0[8'hFD]), 32'h34);
            end
        end

        // DEPTH=4 unit: fill, overflow, partial word rejection
        do_reset();
        for (int i = 0; i < 4; i++)
            do_op($sformatf("small_push%0d", i), 1, 1'b0, 1'b0, 16'(8'h11 * (i + 1)),
                  mk(1'b0, 16'h0000, 2, 1));
        chk("small full", 32'(full[1]), 32'd1);
        chk("small depth4", 32'(depth_count[1]), 32'd4);
        do_op("small_ovf", 1, 1'b0, 1'b0, 16'h0055, mk(1'b1, 16'h0000, 1, 0));
        chk("small depth_after_ovf", 32'(depth_count[1]), 32'd4);
        chk("small sp_after_ovf", 32'(sp[1]), 32'hFB);
        do_op("small_pop", 1, 1'b1, 1'b0, 16'h0000, mk(1'b0, 16'h0044, 4, 1));
        do_op("small_word_ovf", 1, 1'b0, 1'b1, 16'h6677, mk(1'b1, 16'h0044, 1, 0));
        chk("small depth3", 32'(depth_count[1]), 32'd3);
        chk("small mem FC", 32'(mem1[8'hFC]), 32'h44);

        // DEPTH=256 fill: the last push at SP=00 wraps SP to FF
        do_reset();
        for (int i = 0; i < 256; i++)
            do_op($sformatf("fill%0d", i), 0, 1'b0, 1'b0, 16'(i ^ 8'h5A),
                  mk(1'b0, 16'h0000, 2, 1));
        chk("fill full", 32'(full[0]), 32'd1);
        chk("fill depth", 32'(depth_count[0]), 32'd256);
        chk("fill sp", 32'(sp[0]), 32'hFF);
        do_op("fill_ovf", 0, 1'b0, 1'b0, 16'h0077, mk(1'b1, 16'h0000, 1, 0));
        do_op("fill_pop", 0, 1'b1, 1'b0, 16'h0000, mk(1'b0, 16'h00A5, 4, 1));
        chk("fill sp_after_pop", 32'(sp[0]), 32'h00);

        // word pop with clk_en toggling every cycle
        do_reset();
        do_op("cafe_push", 0, 1'b0, 1'b1, 16'hCAFE, mk(1'b0, 16'h0000, 3, 2));
        s0 = n_stall[0];
        toggle_on = 1'b1;
        do_op("cafe_pop", 0, 1'b1, 1'b1, 16'h0000, mk(1'b0, 16'hCAFE, 7, 2));
        toggle_on = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("stall strobes", n_stall[0] - s0, 0);
        chk("cafe sp", 32'(sp[0]), 32'hFF);
        chk("cafe depth", 32'(depth_count[0]), 32'd0);

        // reset during POP_RD of a word pop
        do_op("rst_push", 0, 1'b0, 1'b1, 16'h0102, mk(1'b0, 16'hCAFE, 3, 2));
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_op[0]    = 1'b1;
        req_word[0]  = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_re[0]) found = 1'b1;
            else @(negedge clk);
        end
        chk("midrst pop_rd_seen", 32'(found), 32'd1);
        d0 = n_done[0];
        rst = 1'b1;
        sp_load[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sp_load[0] = 1'b0;
        m0 = n_mem[0];
        s0 = n_sp[0];
        chk("midrst req_ready", 32'(req_ready[0]), 32'd1);
        chk("midrst depth", 32'(depth_count[0]), 32'd0);
        chk("midrst rsp_data", 32'(rsp_data[0]), 32'd0);
        repeat (10) @(negedge clk);
        chk("midrst no_done", n_done[0] - d0, 0);
        chk("midrst no_mem", n_mem[0] - m0, 0);
        chk("midrst no_sp", n_sp[0] - s0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
